stream_sink_ctrl: RTL
=====================

Name: stream_sink_ctrl

Overview:
- Synthesizable, parametrised output-stream sink for image pipelines; successor to the simulation-only output sink.
- Accepts a ready/valid pixel stream for one frame of IMG_W x IMG_H beats and drives backpressure, either always-ready or pseudo-random stalls.
- Tracks column/row, signals line and frame completion, and accumulates a frame checksum for on-chip or bench comparison.

Parameters:
- DATA_W, 8, pixel width in bits.
- IMG_W, 256, beats per line.
- IMG_H, 256, lines per frame.
- STALL_EN, 1, 1 = pseudo-random backpressure, 0 = ready held high in RUN.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.
- SUM_W, 32, checksum width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- start_in  in  1  arm level; the frame starts on its falling edge
- stop_in  in  1  releases DONE back to IDLE
- data_in  in  DATA_W  pixel data
- valid  in  1  upstream data valid
- ready  out  1  sink ready (registered)
- line_end  out  1  one-cycle pulse on acceptance of the last beat of each line
- done  out  1  one-cycle pulse on acceptance of the last beat of the frame
- busy  out  1  high in ARMED or RUN
- col  out  $clog2(IMG_W)  current column
- row  out  $clog2(IMG_H)  current row
- checksum  out  SUM_W  running sum of accepted data_in, modulo 2^SUM_W

Behaviour:
- Reset (reset low, async): state=IDLE; ready=0, line_end=0, done=0, busy=0, col=0, row=0, checksum=0; LFSR=LFSR_SEED; stall counter=0.
- Beat accepted iff ready & valid on a rising clk edge. data_in is zero-extended to SUM_W and added to checksum.
- FSM states and transitions:
  - IDLE: start_in=1 -> ARMED.
  - ARMED: start_in=0 (falling edge) -> RUN. Clear col, row, checksum; ready=1 from the next cycle.
  - RUN: accept beats. On acceptance with col==IMG_W-1: col=0, row+=1, line_end pulses next cycle. If row==IMG_H-1 as well: done pulses next cycle, ready=0, -> DONE.
  - DONE: ready=0. stop_in=1 -> IDLE. start_in is ignored in DONE.
- start_in and stop_in are ignored in RUN; a frame always completes or is reset.
- Stall generator, active only when STALL_EN=1 and state=RUN:
  - 16-bit Fibonacci LFSR with taps 16,14,13,11, advanced every RUN cycle.
  - When stall counter==0 and ready==1, LFSR[0] is sampled. If 1, ready drops next cycle and the counter loads 1+LFSR[3:1] (range 1..8). The counter decrements each cycle; ready returns when it reaches 0.
  - Maximum consecutive ready-low cycles in RUN: 8.
  - With STALL_EN=0, ready=1 throughout RUN.
- Outputs are registered; line_end/done occur exactly one cycle after the accepting edge.
- checksum wraps silently at 2^SUM_W.
- valid while ready=0 produces no state change.
- data_in is don't-care when valid=0.
- Reset asserted mid-frame aborts immediately to reset values; no partial done is issued.

Decomposition:
- Shared package stream_pkg holds:
  - state enum {IDLE, ARMED, RUN, DONE};
  - LFSR_TAPS constant;
  - MAX_STALL=8.
- One sub-module, stream_stall_gen, contains the LFSR and stall counter. Inputs: clk, reset, en, ready_q. Output: stall.

Test Plan:
- IMG_W=4, IMG_H=2, STALL_EN=0, valid always high, data 1..8 after the start_in falling edge -> ready=1 continuously; line_end after beats 4 and 8; done one cycle after beat 8; checksum=36; ready=0 after done.
- STALL_EN=1, seed 16'hACE1, valid always high, IMG 4x2 -> exactly 8 acceptances; no ready-low run exceeds 8 cycles in RUN; ready sequence identical across two runs with the same seed.
- Valid toggled randomly with stalls on, IMG 256x256, data = (col+row)&8'hFF -> 65536 acceptances; checksum matches the bench model; 256 line_end pulses.
- Reset pulled low after beat 5 of an 8-beat frame -> all outputs return to reset values asynchronously; no done; a subsequent start_in pulse yields a full 8-beat frame with checksum restarted from 0.
- start_in and stop_in pulsed during RUN -> no effect; in DONE, stop_in=1 -> IDLE next cycle, busy=0; a new start_in pulse re-arms.
- DATA_W=8, SUM_W=8, data 8'hFF x 4 (IMG 4x1) -> checksum=8'hFC (wrap).

Source files
------------

// File: rtl/stream_pkg.sv
// rtl/stream_pkg.sv - shared types and constants for the stream sink controller
package stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS   = 16'hB400;
  localparam int          MAX_STALL   = 8;
  localparam int          STALL_CNT_W = $clog2(MAX_STALL + 1);

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/stream_stall_gen.sv
// rtl/stream_stall_gen.sv - LFSR-driven backpressure generator
// stall is the next-cycle view, so the parent can register ready directly from it.
module stream_stall_gen
  import stream_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic ready_q,
  output logic stall
);

  // An all-zero seed would lock the LFSR, so it is replaced rather than trusted
  localparam logic [15:0] SEED_SAFE = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  logic [15:0]            r_lfsr;
  logic [STALL_CNT_W-1:0] r_cnt;
  logic [STALL_CNT_W-1:0] w_cnt_nxt;
  logic                   w_fire;

  assign w_fire = en && ready_q && (r_cnt == '0) && r_lfsr[0];

  always_comb begin
    w_cnt_nxt = '0;
    if (!en) begin
      w_cnt_nxt = '0;
    end else if (w_fire) begin
      w_cnt_nxt = STALL_CNT_W'(1) + STALL_CNT_W'(r_lfsr[3:1]);
    end else if (r_cnt != '0) begin
      w_cnt_nxt = r_cnt - STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lfsr <= SEED_SAFE;
      r_cnt  <= '0;
    end else begin
      if (en) begin
        r_lfsr <= lfsr_next(r_lfsr);
      end
      r_cnt <= w_cnt_nxt;
    end
  end

  assign stall = (w_cnt_nxt != '0);

endmodule

// File: rtl/stream_sink_ctrl.sv
// rtl/stream_sink_ctrl.sv - framed ready/valid pixel sink with position tracking and checksum
module stream_sink_ctrl
  import stream_pkg::*;
#(
  parameter int          DATA_W    = 8,
  parameter int          IMG_W     = 256,
  parameter int          IMG_H     = 256,
  parameter int          STALL_EN  = 1,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          SUM_W     = 32,
  localparam int         COL_W     = (IMG_W > 1) ? $clog2(IMG_W) : 1,
  localparam int         ROW_W     = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_in,
  input  logic              stop_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid,
  output logic              ready,
  output logic              line_end,
  output logic              done,
  output logic              busy,
  output logic [COL_W-1:0]  col,
  output logic [ROW_W-1:0]  row,
  output logic [SUM_W-1:0]  checksum
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_ready;
  logic             r_line_end;
  logic             r_done;
  logic             r_busy;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic [SUM_W-1:0] r_sum;

  logic w_acc;
  logic w_last_col;
  logic w_last_row;
  logic w_stall_en;
  logic w_stall;

  assign w_acc      = r_ready && valid;
  assign w_last_col = (r_col == COL_LAST);
  assign w_last_row = (r_row == ROW_LAST);
  assign w_stall_en = (STALL_EN != 0) && (r_state == RUN);

  stream_stall_gen #(
    .LFSR_SEED (LFSR_SEED)
  ) u_stall_gen (
    .clk     (clk),
    .reset   (reset),
    .en      (w_stall_en),
    .ready_q (r_ready),
    .stall   (w_stall)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // start_in/stop_in are only looked at outside RUN, so a frame cannot be cut short
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start_in) w_state_nxt = ARMED;
      ARMED:   if (!start_in) w_state_nxt = RUN;
      RUN:     if (w_acc && w_last_col && w_last_row) w_state_nxt = DONE;
      DONE:    if (stop_in) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ready    <= 1'b0;
      r_line_end <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_col      <= '0;
      r_row      <= '0;
      r_sum      <= '0;
    end else begin
      r_ready    <= (w_state_nxt == RUN) && !w_stall;
      r_busy     <= (w_state_nxt == ARMED) || (w_state_nxt == RUN);
      r_line_end <= w_acc && w_last_col;
      r_done     <= w_acc && w_last_col && w_last_row;
      if (r_state == ARMED && w_state_nxt == RUN) begin
        r_col <= '0;
        r_row <= '0;
        r_sum <= '0;
      end else if (w_acc) begin
        r_sum <= r_sum + SUM_W'(data_in);
        if (w_last_col) begin
          r_col <= '0;
          r_row <= w_last_row ? '0 : r_row + ROW_W'(1);
        end else begin
          r_col <= r_col + COL_W'(1);
        end
      end
    end
  end

  assign ready    = r_ready;
  assign line_end = r_line_end;
  assign done     = r_done;
  assign busy     = r_busy;
  assign col      = r_col;
  assign row      = r_row;
  assign checksum = r_sum;

endmodule
